// File: rtl/access_controller.sv
// Access controller: requests a code compare, then grants a timed unlock or applies a lockout/alarm.
// Optional build macro ALARM_CLEAR_EN adds the alarm_clr keyholder acknowledge input.
module access_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 100,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic       match,
`ifdef ALARM_CLEAR_EN
    input  logic       alarm_clr,
`endif
    output logic       cmp_en,
    output logic       busy,
    output logic       unlock,
    output logic       lockout,
    output logic       alarm,
    output logic [2:0] fail_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, CHECK, GRANT, DENY, LOCKOUT, ALARM
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [2:0]         fail_q, fail_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE:  if (code_valid) state_d = LOAD;
            LOAD:  state_d = CHECK;
            CHECK: begin
                if (match) begin
                    state_d = GRANT;
                    timer_d = CNT_W'(UNLOCK_CYCLES - 1);
                    fail_d  = '0;
                end else begin
                    state_d = DENY;
                end
            end
            GRANT, LOCKOUT: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            DENY: begin
                // Saturating increment; reaching the limit is terminal.
                if (fail_q >= 3'(MAX_FAILS - 1)) begin
                    fail_d  = 3'(MAX_FAILS);
                    state_d = ALARM;
                end else begin
                    fail_d  = fail_q + 3'd1;
                    state_d = LOCKOUT;
                    timer_d = CNT_W'(LOCKOUT_CYCLES - 1);
                end
            end
            ALARM: begin
`ifdef ALARM_CLEAR_EN
                if (alarm_clr) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmp_en     = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign unlock     = (state_q == GRANT);
    assign lockout    = (state_q == LOCKOUT) || (state_q == ALARM);
    assign alarm      = (state_q == ALARM);
    assign fail_count = fail_q;

endmodule

// File: tb/tb_access_controller.sv
// Directed bench for access_controller with UNLOCK=4, LOCKOUT=3, MAX_FAILS=3.
module tb_access_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       code_valid = 1'b0;
    logic       match = 1'b0;
`ifdef ALARM_CLEAR_EN
    logic       alarm_clr = 1'b0;
`endif
    logic       cmp_en, busy, unlock, lockout, alarm;
    logic [2:0] fail_count;
    int         checks = 0;
    int         failures = 0;

    access_controller #(
        .MAX_FAILS(3), .UNLOCK_CYCLES(4), .LOCKOUT_CYCLES(3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .match(match),
`ifdef ALARM_CLEAR_EN
        .alarm_clr(alarm_clr),
`endif
        .cmp_en(cmp_en), .busy(busy), .unlock(unlock), .lockout(lockout),
        .alarm(alarm), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // One clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        code_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Leaves the bench in the LOAD cycle (pulse cycle + 1).
    task automatic pulse_code(input logic m);
        match = m;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        code_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmp_en, busy, unlock, lockout, alarm, fail_count} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {cmp_en, busy, unlock, lockout, alarm, fail_count});
        end
        code_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_grant();
        do_reset();
        pulse_code(1'b1);                         // cycle 11
        checks++;
        if (cmp_en !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL grant_load cmp_en=%b busy=%b exp=1,1", cmp_en, busy);
        end
        tick();                                   // cycle 12
        checks++;
        if (cmp_en !== 1'b0 || unlock !== 1'b0) begin
            failures++; $display("FAIL grant_check cmp_en=%b unlock=%b exp=0,0", cmp_en, unlock);
        end
        for (int c = 13; c <= 16; c++) begin
            tick();
            checks++;
            if (unlock !== 1'b1 || cmp_en !== 1'b0) begin
                failures++; $display("FAIL grant_unlock cycle=%0d unlock=%b cmp_en=%b exp=1,0", c, unlock, cmp_en);
            end
        end
        tick();                                   // cycle 17
        checks++;
        if (unlock !== 1'b0 || busy !== 1'b0 || fail_count !== 3'd0) begin
            failures++; $display("FAIL grant_exit unlock=%b busy=%b fail=%0d exp=0,0,0", unlock, busy, fail_count);
        end
    endtask

    task automatic test_single_fail();
        do_reset();
        pulse_code(1'b0);                         // 11
        tick();                                   // 12
        tick();                                   // 13 DENY
        checks++;
        if (fail_count !== 3'd0 || busy !== 1'b1 || lockout !== 1'b0) begin
            failures++; $display("FAIL deny_cycle fail=%0d busy=%b lockout=%b exp=0,1,0", fail_count, busy, lockout);
        end
        tick();                                   // 14
        checks++;
        if (lockout !== 1'b1 || fail_count !== 3'd1 || unlock !== 1'b0) begin
            failures++; $display("FAIL lockout_start lockout=%b fail=%0d unlock=%b exp=1,1,0", lockout, fail_count, unlock);
        end
        tick();                                   // 15
        code_valid = 1'b1;
        tick();                                   // 16
        code_valid = 1'b0;
        checks++;
        if (lockout !== 1'b1 || cmp_en !== 1'b0) begin
            failures++; $display("FAIL lockout_ignore lockout=%b cmp_en=%b exp=1,0", lockout, cmp_en);
        end
        tick();                                   // 17
        checks++;
        if (busy !== 1'b0 || lockout !== 1'b0 || fail_count !== 3'd1) begin
            failures++; $display("FAIL lockout_exit busy=%b lockout=%b fail=%0d exp=0,0,1", busy, lockout, fail_count);
        end
        tick();                                   // 18
        checks++;
        if (cmp_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL lockout_not_queued cmp_en=%b busy=%b exp=0,0", cmp_en, busy);
        end
    endtask

    task automatic test_alarm();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            pulse_code(1'b0);
            tick(); tick(); tick();               // N+4
            checks++;
            if (fail_count !== 3'(k) || lockout !== 1'b1 || alarm !== (k == 3)) begin
                failures++; $display("FAIL alarm_seq k=%0d fail=%0d lockout=%b alarm=%b", k, fail_count, lockout, alarm);
            end
            if (k < 3) begin
                tick(); tick(); tick();           // back to IDLE
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (alarm !== 1'b1 || lockout !== 1'b1 || fail_count !== 3'd3) begin
                failures++; $display("FAIL alarm_hold c=%0d alarm=%b lockout=%b fail=%0d exp=1,1,3", c, alarm, lockout, fail_count);
            end
        end
        pulse_code(1'b1);
        checks++;
        if (cmp_en !== 1'b0 || alarm !== 1'b1) begin
            failures++; $display("FAIL alarm_ignore_code cmp_en=%b alarm=%b exp=0,1", cmp_en, alarm);
        end
        tick();
        checks++;
        if (cmp_en !== 1'b0 || unlock !== 1'b0) begin
            failures++; $display("FAIL alarm_no_grant cmp_en=%b unlock=%b exp=0,0", cmp_en, unlock);
        end
`ifdef ALARM_CLEAR_EN
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        checks++;
        if (alarm !== 1'b0 || lockout !== 1'b0 || fail_count !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL alarm_clr alarm=%b lockout=%b fail=%0d busy=%b exp=0,0,0,0", alarm, lockout, fail_count, busy);
        end
`else
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (alarm !== 1'b0 || lockout !== 1'b0 || fail_count !== 3'd0) begin
            failures++; $display("FAIL alarm_reset alarm=%b lockout=%b fail=%0d exp=0,0,0", alarm, lockout, fail_count);
        end
`endif
    endtask

    task automatic test_wrong_wrong_right();
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            pulse_code(1'b0);
            tick(); tick(); tick(); tick(); tick(); tick();   // N+7, IDLE
            checks++;
            if (fail_count !== 3'(k) || busy !== 1'b0 || alarm !== 1'b0) begin
                failures++; $display("FAIL wwr_fail k=%0d fail=%0d busy=%b alarm=%b", k, fail_count, busy, alarm);
            end
        end
        pulse_code(1'b1);
        tick();
        for (int c = 13; c <= 16; c++) begin
            tick();
            checks++;
            if (unlock !== 1'b1 || fail_count !== 3'd0 || alarm !== 1'b0) begin
                failures++; $display("FAIL wwr_grant cycle=%0d unlock=%b fail=%0d alarm=%b exp=1,0,0", c, unlock, fail_count, alarm);
            end
        end
        tick();
        checks++;
        if (unlock !== 1'b0 || busy !== 1'b0 || alarm !== 1'b0) begin
            failures++; $display("FAIL wwr_exit unlock=%b busy=%b alarm=%b exp=0,0,0", unlock, busy, alarm);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        pulse_code(1'b1);
        tick(); tick(); tick();                   // 14, second unlock cycle
        checks++;
        if (unlock !== 1'b1) begin
            failures++; $display("FAIL midgrant_pre unlock=%b exp=1", unlock);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (unlock !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midgrant_reset unlock=%b busy=%b exp=0,0", unlock, busy);
        end
        tick();
        checks++;
        if (unlock !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midgrant_idle unlock=%b busy=%b exp=0,0", unlock, busy);
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_single_fail();
        test_alarm();
        test_wrong_wrong_right();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
